packetizer: RTL and testbench
=============================

# packetizer

Transmit-side framer for the mixed BPSK/QPSK link. It accepts payload bytes on an AXI-Stream slave and emits one symbol per `clk_enable` strobe to the modulator. Each frame is a PN training sequence, then a 64-symbol BPSK header, then the payload in the selected modulation, then a guard gap. The frame format matches what the mixed-mode receive depacketizer parses.

## Interface
- `TRN_LEN`, 30: training symbols per frame.
- `GAP_LEN`, 8: idle symbols after the payload, before IDLE.
- `SIGNATURE`, 8'hA5: header signature byte.
- `clk` in 1: sole clock. One clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clk_enable` in 1: symbol strobe. State and outputs advance only when it is high.
- `tx_start` in 1: frame request, sampled in IDLE.
- `tx_bpsk` in 1: payload modulation. 1 = BPSK, 0 = QPSK. Latched with `tx_start`.
- `pld_bytes` in 13: payload byte count. Latched with `tx_start`.
- `s_tdata` in 8: payload byte. Sent MSB first.
- `s_tvalid` in 1, `s_tready` out 1, `s_tlast` in 1: AXIS slave.
- `out_QPSK` out 2: symbol bits {I,Q}.
- `out_BPSK` out 1: BPSK symbol bit.
- `out_valid` out 1: symbol is part of a frame.
- `is_bpsk` out 1: current symbol is BPSK.
- `tx_busy` out 1: state is not IDLE.
- `tx_done` out 1: one-clk pulse on the GAP→IDLE transition.
- `err_underrun` out 1: sticky flag, cleared by `tx_start` or reset.
- `err_len` out 1: sticky flag, cleared by `tx_start` or reset.

## Operation
- States: IDLE, TRN, HDR, PLD, GAP. One-hot encoding.
- All transitions and counter updates occur only on cycles where `clk_enable` is high.
- **IDLE**
  - Registered outputs hold 0, except `is_bpsk` = 1.
  - On `tx_start`: latch `tx_bpsk` and `pld_bytes`, seed the LFSR to 7'h7F, clear both error flags, go to TRN.
- **TRN**
  - Emit `TRN_LEN` BPSK symbols. Each symbol bit is LFSR[6].
  - LFSR polynomial x^7+x^6+1, shifted once per symbol.
  - Go to HDR after the last training symbol.
- **HDR**
  - Emit 64 BPSK symbols, MSB first, in this order:
    - MCS[7:0] = {2'b00, bpsk_l, 5'b0}.
    - LEN[15:0] = payload bits = `pld_bytes`×8.
    - `SIGNATURE`.
    - 32 zero bits.
  - After symbol 63: if `pld_bytes` = 0 go to GAP, else go to PLD.
- **PLD**
  - BPSK: 8 symbols per byte, bits b7..b0.
  - QPSK: 4 symbols per byte as {b7,b6}, {b5,b4}, {b3,b2}, {b1,b0}.
  - Total symbols: LEN for BPSK, LEN/2 for QPSK. Go to GAP after the last one.
- **GAP**
  - `out_valid` = 0 and symbols = 0 for `GAP_LEN` strobes.
  - Then pulse `tx_done` and go to IDLE.
- **Symbol mapping**
  - BPSK symbols (training and header): `out_BPSK` = b, `out_QPSK` = {b,b}.
  - QPSK payload symbols: `out_QPSK` = pair, `out_BPSK` = pair[1].
- **Input buffering:** a one-byte holding register feeds a byte shift register.
  - `s_tready` = (state is HDR or PLD) && holding register empty. The first byte is therefore prefetched during HDR.
  - On the strobe that emits the last symbol of a byte, the shift register reloads from the holding register.
- **Underrun:** at a reload strobe in PLD with the holding register empty:
  - Set `err_underrun`.
  - Load 8'h00 and emit zero symbols for that byte.
  - Continue counting so the frame length is unchanged.
- **Length check:** set `err_len` if either:
  - `s_tlast` is seen on any byte other than byte number `pld_bytes`, or
  - the last byte is accepted without `s_tlast`.
  - No framing change in either case. Bytes arriving after the frame stay unaccepted until the next frame.
- **Other rules**
  - `tx_start` outside IDLE is ignored.
  - An async assert of `rst_n` in mid-frame returns to IDLE immediately and discards any held byte.
  - Counters: 7-bit training, 6-bit header, 16-bit payload symbol count. The count compares against LEN−1 (BPSK) or LEN/2−1 (QPSK).

## Timing
- Every output is registered.
- Symbol k of a frame appears one `clk` after the k-th strobe following the `tx_start` strobe, and is held until the next strobe.
- Reset values:
  - `out_QPSK` = 0, `out_BPSK` = 0, `out_valid` = 0.
  - `is_bpsk` = 1.
  - `s_tready` = 0, `tx_busy` = 0, `tx_done` = 0.
  - Both error flags = 0. LFSR = 7'h7F.
- `is_bpsk` follows `bpsk_l` from the first PLD symbol, and returns to 1 in GAP.
- `out_valid` = 1 through TRN, HDR and PLD.
- Frame length in strobes: TRN_LEN + 64 + PLD symbols + GAP_LEN.
- `s_tready` may be high on cycles without a strobe. A handshake completes on any `clk` with `s_tvalid` && `s_tready`, independent of `clk_enable`.

## Test plan
- `pld_bytes`=2, `tx_bpsk`=1, bytes 8'hC3, 8'h5A (tlast on the 2nd), `clk_enable` always 1 → header LEN = 16'd16, MCS = 8'h20; 16 payload symbols 1100001101011010; `tx_done` at strobe 30+64+16+8; no error flags.
- Same bytes with `tx_bpsk`=0 → MCS = 8'h00; 8 QPSK symbols 11,00,00,11,01,01,10,10; `is_bpsk`=0 only during PLD.
- `pld_bytes`=0 → 94 valid symbols, LEN = 0, then GAP; `s_tready` never handshakes.
- `clk_enable` high 1 in 4 cycles, `s_tvalid` withheld for the 2nd byte → `err_underrun`=1, second byte emitted as zeros, frame length unchanged.
- `s_tlast` on byte 1 of 3 → `err_len`=1, all 3 bytes still sent. Separately, `rst_n` pulsed low mid-PLD → all outputs return to reset values immediately.

Source files
------------

// File: rtl/packetizer.sv
// Transmit framer for the mixed BPSK/QPSK link.
// Frame layout: PN training, 64-bit BPSK header, payload (BPSK or QPSK), guard gap.
// One symbol is produced per clk_enable strobe. Payload bytes arrive on an
// AXI-Stream slave through a one-byte holding register.
module packetizer #(
   parameter int         TRN_LEN   = 30,
   parameter int         GAP_LEN   = 8,
   parameter logic [7:0] SIGNATURE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_enable,
   input  logic        tx_start,
   input  logic        tx_bpsk,
   input  logic [12:0] pld_bytes,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   output logic [1:0]  out_QPSK,
   output logic        out_BPSK,
   output logic        out_valid,
   output logic        is_bpsk,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        err_underrun,
   output logic        err_len
);

   // One-hot frame states
   localparam logic [4:0] S_IDLE = 5'b00001;
   localparam logic [4:0] S_TRN  = 5'b00010;
   localparam logic [4:0] S_HDR  = 5'b00100;
   localparam logic [4:0] S_PLD  = 5'b01000;
   localparam logic [4:0] S_GAP  = 5'b10000;

   logic [4:0]  r_state, w_state_n;
   logic [6:0]  r_lfsr, w_lfsr_n;
   logic [6:0]  r_tcnt, w_tcnt_n;      // training count, reused as gap count
   logic [5:0]  r_hcnt, w_hcnt_n;
   logic [15:0] r_pcnt, w_pcnt_n;
   logic        r_bpsk_l, w_bpsk_n;
   logic [12:0] r_len_b, w_len_n;
   logic [12:0] r_acc, w_acc_n;        // bytes accepted this frame
   logic [7:0]  r_hold, w_hold_n;
   logic        r_hold_v, w_hold_v_n;
   logic [7:0]  r_sh, w_sh_n;
   logic        r_err_u, w_err_u_n;
   logic        r_err_l, w_err_l_n;
   logic        r_obpsk, w_obpsk_n;
   logic [1:0]  r_oqpsk, w_oqpsk_n;
   logic        r_ovalid, w_ovalid_n;
   logic        r_isbpsk, w_isbpsk_n;
   logic        r_done, w_done_n;
   logic        r_tready, w_tready_n;

   logic        w_hs;
   logic        w_reload;
   logic        w_bit;
   logic [15:0] w_len;
   logic [15:0] w_pld_last;
   logic [63:0] w_hdr;

   assign w_hs       = s_tvalid & r_tready;
   assign w_len      = {r_len_b, 3'b000};
   assign w_pld_last = r_bpsk_l ? (w_len - 16'd1) : ({1'b0, w_len[15:1]} - 16'd1);
   assign w_hdr      = {2'b00, r_bpsk_l, 5'b00000, w_len, SIGNATURE, 32'h0};

   // Next-state, datapath and output computation
   always_comb begin
      w_state_n  = r_state;
      w_lfsr_n   = r_lfsr;
      w_tcnt_n   = r_tcnt;
      w_hcnt_n   = r_hcnt;
      w_pcnt_n   = r_pcnt;
      w_bpsk_n   = r_bpsk_l;
      w_len_n    = r_len_b;
      w_acc_n    = r_acc;
      w_hold_n   = r_hold;
      w_hold_v_n = r_hold_v;
      w_sh_n     = r_sh;
      w_err_u_n  = r_err_u;
      w_err_l_n  = r_err_l;
      w_obpsk_n  = r_obpsk;
      w_oqpsk_n  = r_oqpsk;
      w_ovalid_n = r_ovalid;
      w_isbpsk_n = r_isbpsk;
      w_done_n   = 1'b0;
      w_reload   = 1'b0;
      w_bit      = 1'b0;
      w_tready_n = 1'b0;

      // Handshakes complete on any clk; tlast must coincide exactly with the last byte
      if (w_hs) begin
         w_hold_n   = s_tdata;
         w_hold_v_n = 1'b1;
         w_acc_n    = r_acc + 13'd1;
         if (s_tlast != ((r_acc + 13'd1) == r_len_b))
            w_err_l_n = 1'b1;
      end

      if (clk_enable) begin
         case (r_state)
            S_IDLE: begin
               w_obpsk_n  = 1'b0;
               w_oqpsk_n  = 2'b00;
               w_ovalid_n = 1'b0;
               w_isbpsk_n = 1'b1;
               if (tx_start) begin
                  w_bpsk_n   = tx_bpsk;
                  w_len_n    = pld_bytes;
                  w_lfsr_n   = 7'h7F;
                  w_err_u_n  = 1'b0;
                  w_err_l_n  = 1'b0;
                  w_acc_n    = 13'd0;
                  w_hold_v_n = 1'b0;
                  w_tcnt_n   = 7'd0;
                  w_state_n  = S_TRN;
               end
            end
            S_TRN: begin
               w_bit      = r_lfsr[6];
               w_obpsk_n  = w_bit;
               w_oqpsk_n  = {w_bit, w_bit};
               w_ovalid_n = 1'b1;
               w_isbpsk_n = 1'b1;
               w_lfsr_n   = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
               if (r_tcnt == 7'(TRN_LEN - 1)) begin
                  w_state_n = S_HDR;
                  w_hcnt_n  = 6'd0;
               end else begin
                  w_tcnt_n = r_tcnt + 7'd1;
               end
            end
            S_HDR: begin
               w_bit      = w_hdr[~r_hcnt];
               w_obpsk_n  = w_bit;
               w_oqpsk_n  = {w_bit, w_bit};
               w_ovalid_n = 1'b1;
               w_isbpsk_n = 1'b1;
               if (r_hcnt == 6'd63) begin
                  if (r_len_b == 13'd0) begin
                     w_state_n = S_GAP;
                     w_tcnt_n  = 7'd0;
                  end else begin
                     // first payload byte moves from the prefetch register here
                     w_state_n = S_PLD;
                     w_pcnt_n  = 16'd0;
                     w_reload  = 1'b1;
                  end
               end else begin
                  w_hcnt_n = r_hcnt + 6'd1;
               end
            end
            S_PLD: begin
               w_ovalid_n = 1'b1;
               w_isbpsk_n = r_bpsk_l;
               w_obpsk_n  = r_sh[7];
               if (r_bpsk_l) begin
                  w_oqpsk_n = {r_sh[7], r_sh[7]};
                  w_sh_n    = {r_sh[6:0], 1'b0};
               end else begin
                  w_oqpsk_n = r_sh[7:6];
                  w_sh_n    = {r_sh[5:0], 2'b00};
               end
               if (r_pcnt == w_pld_last) begin
                  w_state_n = S_GAP;
                  w_tcnt_n  = 7'd0;
               end else begin
                  w_pcnt_n = r_pcnt + 16'd1;
                  w_reload = r_bpsk_l ? (r_pcnt[2:0] == 3'd7) : (r_pcnt[1:0] == 2'd3);
               end
            end
            S_GAP: begin
               w_obpsk_n  = 1'b0;
               w_oqpsk_n  = 2'b00;
               w_ovalid_n = 1'b0;
               w_isbpsk_n = 1'b1;
               if (r_tcnt == 7'(GAP_LEN - 1)) begin
                  w_state_n = S_IDLE;
                  w_done_n  = 1'b1;
               end else begin
                  w_tcnt_n = r_tcnt + 7'd1;
               end
            end
            default: w_state_n = S_IDLE;
         endcase
      end

      // Byte boundary: take the held byte, or substitute zeros and flag underrun.
      // A handshake in this same clk only happens when the holder was empty, so
      // it is left to fill the holder for the next byte.
      if (w_reload) begin
         if (r_hold_v) begin
            w_sh_n     = r_hold;
            w_hold_v_n = 1'b0;
         end else begin
            w_sh_n    = 8'h00;
            w_err_u_n = 1'b1;
         end
      end

      // Ready only while the frame still owes bytes, so later bytes wait for the next frame
      w_tready_n = ((w_state_n == S_HDR) || (w_state_n == S_PLD)) && !w_hold_v_n &&
                   (w_acc_n != w_len_n);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_lfsr   <= 7'h7F;
         r_tcnt   <= 7'd0;
         r_hcnt   <= 6'd0;
         r_pcnt   <= 16'd0;
         r_bpsk_l <= 1'b1;
         r_len_b  <= 13'd0;
         r_acc    <= 13'd0;
         r_hold   <= 8'h00;
         r_hold_v <= 1'b0;
         r_sh     <= 8'h00;
         r_err_u  <= 1'b0;
         r_err_l  <= 1'b0;
         r_obpsk  <= 1'b0;
         r_oqpsk  <= 2'b00;
         r_ovalid <= 1'b0;
         r_isbpsk <= 1'b1;
         r_done   <= 1'b0;
         r_tready <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_lfsr   <= w_lfsr_n;
         r_tcnt   <= w_tcnt_n;
         r_hcnt   <= w_hcnt_n;
         r_pcnt   <= w_pcnt_n;
         r_bpsk_l <= w_bpsk_n;
         r_len_b  <= w_len_n;
         r_acc    <= w_acc_n;
         r_hold   <= w_hold_n;
         r_hold_v <= w_hold_v_n;
         r_sh     <= w_sh_n;
         r_err_u  <= w_err_u_n;
         r_err_l  <= w_err_l_n;
         r_obpsk  <= w_obpsk_n;
         r_oqpsk  <= w_oqpsk_n;
         r_ovalid <= w_ovalid_n;
         r_isbpsk <= w_isbpsk_n;
         r_done   <= w_done_n;
         r_tready <= w_tready_n;
      end
   end

   assign s_tready     = r_tready;
   assign out_QPSK     = r_oqpsk;
   assign out_BPSK     = r_obpsk;
   assign out_valid    = r_ovalid;
   assign is_bpsk      = r_isbpsk;
   assign tx_busy      = ~r_state[0];
   assign tx_done      = r_done;
   assign err_underrun = r_err_u;
   assign err_len      = r_err_l;

endmodule

// File: tb/tb_packetizer.sv
// Directed bench for packetizer: captures every strobed symbol of a frame and
// compares it with a frame built from the documented format.
module tb_packetizer;

   logic        clk, rst_n, clk_enable, tx_start, tx_bpsk;
   logic [12:0] pld_bytes;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tready, s_tlast;
   logic [1:0]  out_QPSK;
   logic        out_BPSK, out_valid, is_bpsk, tx_busy, tx_done, err_underrun, err_len;

   packetizer #(.TRN_LEN(30), .GAP_LEN(8), .SIGNATURE(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .tx_start(tx_start),
      .tx_bpsk(tx_bpsk), .pld_bytes(pld_bytes), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tready(s_tready), .s_tlast(s_tlast), .out_QPSK(out_QPSK), .out_BPSK(out_BPSK),
      .out_valid(out_valid), .is_bpsk(is_bpsk), .tx_busy(tx_busy), .tx_done(tx_done),
      .err_underrun(err_underrun), .err_len(err_len));

   int n_checks = 0;
   int n_err    = 0;

   int cyc    = 0;
   int en_div = 1;

   logic [7:0] src_d [8];
   bit         src_l [8];
   int         src_lim = 0, src_gen = 0, my_gen = 0, src_ptr = 0, hs_cnt = 0;
   bit         hs_armed = 0;

   logic [7:0] exp_b [8];
   logic       rec_v [400], rec_b [400], rec_i [400], rec_d [400], rec_y [400];
   logic [1:0] rec_q [400];
   int         nsym;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // symbol strobe: high 1 in en_div cycles, changes only on negedge
   always @(negedge clk) begin
      cyc = cyc + 1;
      clk_enable = (en_div <= 1) || (cyc % en_div == 0);
   end

   // AXIS source: a handshake is known at negedge to land on the next posedge
   always @(negedge clk) begin
      if (my_gen != src_gen) begin
         my_gen   = src_gen;
         src_ptr  = 0;
         hs_armed = 0;
      end else if (hs_armed) begin
         src_ptr = src_ptr + 1;
         hs_cnt  = hs_cnt + 1;
      end
      if (src_ptr < src_lim) begin
         s_tvalid = 1'b1;
         s_tdata  = src_d[src_ptr];
         s_tlast  = src_l[src_ptr];
      end else begin
         s_tvalid = 1'b0;
         s_tdata  = 8'h00;
         s_tlast  = 1'b0;
      end
      hs_armed = s_tvalid && s_tready;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_src(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [2:0] lastm);
      src_d[0] = b0; src_d[1] = b1; src_d[2] = b2;
      src_l[0] = lastm[0]; src_l[1] = lastm[1]; src_l[2] = lastm[2];
      src_lim = n;
      src_gen = src_gen + 1;
      repeat (2) @(negedge clk);
   endtask

   // stop_at = 0 runs the whole frame, otherwise stops after stop_at strobes
   task automatic run_frame(input bit bpsk, input int nb, input int stop_at);
      int t;
      bit done;
      tx_bpsk   = bpsk;
      pld_bytes = 13'(nb);
      tx_start  = 1'b1;
      t = 0;
      while (!tx_busy && t < 100) begin @(posedge clk); #1; t++; end
      tx_start = 1'b0;
      check("start_busy", tx_busy, 1);
      nsym = 0; done = 0; t = 0;
      while (!done && t < 5000 && !(stop_at > 0 && nsym >= stop_at) && nsym < 400) begin
         @(posedge clk); #1; t++;
         if (clk_enable) begin
            rec_v[nsym] = out_valid; rec_b[nsym] = out_BPSK; rec_q[nsym] = out_QPSK;
            rec_i[nsym] = is_bpsk;   rec_d[nsym] = tx_done;  rec_y[nsym] = tx_busy;
            nsym++;
            if (tx_done) done = 1;
         end
      end
      if (stop_at == 0) begin
         check("frame_done", done, 1);
         @(posedge clk); #1;
         check("done_pulse_1clk", tx_done, 0);
      end
   endtask

   task automatic cmp_frame(input string tag, input bit bpsk, input int nb);
      logic [6:0]  lf;
      logic [63:0] hdr;
      logic [7:0]  by;
      logic [1:0]  eq;
      logic        eb, ev, ei;
      int np, j, mv, mb, mq, mi, md, my;
      np = bpsk ? nb * 8 : nb * 4;
      check($sformatf("%s_len", tag), nsym, 30 + 64 + np + 8);
      hdr = {2'b00, bpsk, 5'b00000, 16'(nb * 8), 8'hA5, 32'h0};
      lf = 7'h7F;
      mv = 0; mb = 0; mq = 0; mi = 0; md = 0; my = 0;
      for (int k = 0; k < nsym; k++) begin
         if (k < 30) begin
            eb = lf[6]; eq = {eb, eb}; ev = 1; ei = 1;
            lf = {lf[5:0], lf[6] ^ lf[5]};
         end else if (k < 94) begin
            eb = hdr[63 - (k - 30)]; eq = {eb, eb}; ev = 1; ei = 1;
         end else if (k < 94 + np) begin
            j = k - 94;
            by = exp_b[bpsk ? j / 8 : j / 4];
            if (bpsk) begin eb = by[7 - (j % 8)]; eq = {eb, eb}; end
            else begin eq = by[7 - 2 * (j % 4) -: 2]; eb = eq[1]; end
            ev = 1; ei = bpsk;
         end else begin
            eb = 0; eq = 2'b00; ev = 0; ei = 1;
         end
         if (rec_v[k] !== ev) mv++;
         if (rec_b[k] !== eb) mb++;
         if (rec_q[k] !== eq) mq++;
         if (rec_i[k] !== ei) mi++;
         if (rec_d[k] !== (k == nsym - 1)) md++;
         if (rec_y[k] !== (k != nsym - 1)) my++;
      end
      check($sformatf("%s_valid_mism", tag), mv, 0);
      check($sformatf("%s_bpsk_mism", tag), mb, 0);
      check($sformatf("%s_qpsk_mism", tag), mq, 0);
      check($sformatf("%s_isbpsk_mism", tag), mi, 0);
      check($sformatf("%s_done_mism", tag), md, 0);
      check($sformatf("%s_busy_mism", tag), my, 0);
   endtask

   initial begin
      logic [63:0] hv;
      logic [15:0] pv;
      logic [7:0]  tv;
      int h0, cnt;
      rst_n = 1'b0; tx_start = 1'b0; tx_bpsk = 1'b0; pld_bytes = 13'd0;
      repeat (2) @(posedge clk); #1;
      check("rst_qpsk", out_QPSK, 0);
      check("rst_bpsk", out_BPSK, 0);
      check("rst_valid", out_valid, 0);
      check("rst_isbpsk", is_bpsk, 1);
      check("rst_tready", s_tready, 0);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
      check("rst_err_u", err_underrun, 0);
      check("rst_err_l", err_len, 0);
      @(negedge clk); rst_n = 1'b1;

      // 2-byte BPSK frame
      load_src(2, 8'hC3, 8'h5A, 8'h00, 3'b010);
      exp_b[0] = 8'hC3; exp_b[1] = 8'h5A;
      h0 = hs_cnt;
      run_frame(1, 2, 0);
      cmp_frame("bpsk2", 1, 2);
      for (int k = 0; k < 64; k++) hv[63 - k] = rec_b[30 + k];
      for (int k = 0; k < 16; k++) pv[15 - k] = rec_b[94 + k];
      for (int k = 0; k < 8; k++)  tv[7 - k]  = rec_b[k];
      check("bpsk2_trn_first8", tv, 8'b11111110);
      check("bpsk2_mcs", hv[63:56], 8'h20);
      check("bpsk2_hdr_len", hv[55:40], 16'd16);
      check("bpsk2_sig", hv[39:32], 8'hA5);
      check("bpsk2_hdr_pad", hv[31:0], 32'h0);
      check("bpsk2_payload", pv, 16'b1100001101011010);
      check("bpsk2_err_u", err_underrun, 0);
      check("bpsk2_err_l", err_len, 0);
      check("bpsk2_hs", hs_cnt - h0, 2);

      // same bytes, QPSK payload
      load_src(2, 8'hC3, 8'h5A, 8'h00, 3'b010);
      run_frame(0, 2, 0);
      cmp_frame("qpsk2", 0, 2);
      for (int k = 0; k < 8; k++) hv[63 - k] = rec_b[30 + k];
      for (int k = 0; k < 8; k++) pv[15 - 2 * k -: 2] = rec_q[94 + k];
      cnt = 0;
      for (int k = 0; k < nsym; k++) if (rec_i[k] === 1'b0) cnt++;
      check("qpsk2_mcs", hv[63:56], 8'h00);
      check("qpsk2_pairs", pv, 16'b1100001101011010);
      check("qpsk2_isbpsk0_cnt", cnt, 8);
      check("qpsk2_err_l", err_len, 0);

      // empty payload: a byte is offered but must never be taken
      load_src(1, 8'h77, 8'h00, 8'h00, 3'b001);
      h0 = hs_cnt;
      run_frame(1, 0, 0);
      cmp_frame("zero", 1, 0);
      cnt = 0;
      for (int k = 0; k < nsym; k++) if (rec_v[k] === 1'b1) cnt++;
      for (int k = 0; k < 64; k++) hv[63 - k] = rec_b[30 + k];
      check("zero_valid_cnt", cnt, 94);
      check("zero_hdr_len", hv[55:40], 16'd0);
      check("zero_hs", hs_cnt - h0, 0);

      // sparse strobes, second byte never supplied
      en_div = 4;
      load_src(1, 8'hC3, 8'h00, 8'h00, 3'b000);
      exp_b[0] = 8'hC3; exp_b[1] = 8'h00;
      run_frame(1, 2, 0);
      cmp_frame("undr", 1, 2);
      check("undr_err_u", err_underrun, 1);
      check("undr_err_l", err_len, 0);
      en_div = 1;

      // tlast on the first of three bytes
      load_src(3, 8'h11, 8'h22, 8'h33, 3'b001);
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
      h0 = hs_cnt;
      run_frame(1, 3, 0);
      cmp_frame("len", 1, 3);
      check("len_err_l", err_len, 1);
      check("len_err_u_cleared", err_underrun, 0);
      check("len_hs", hs_cnt - h0, 3);

      // async reset in the middle of a QPSK payload
      load_src(3, 8'h11, 8'h22, 8'h33, 3'b100);
      run_frame(0, 3, 100);
      check("mid_valid_pre", out_valid, 1);
      check("mid_isbpsk_pre", is_bpsk, 0);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_bpsk", out_BPSK, 0);
      check("mid_rst_qpsk", out_QPSK, 0);
      check("mid_rst_isbpsk", is_bpsk, 1);
      check("mid_rst_busy", tx_busy, 0);
      check("mid_rst_tready", s_tready, 0);
      check("mid_rst_done", tx_done, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      check("post_rst_idle", tx_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
